// File: rtl/out_port_credit_reg_pkg.sv
// Shared NoC parameters and helpers for the output-port credit register slice.
package out_port_credit_reg_pkg;

    localparam int NOC_V  = 4;
    localparam int NOC_P  = 5;
    localparam int NOC_FW = 36;
    localparam int NOC_B  = 4;

    // Counter must hold every value 0..B inclusive.
    function automatic int cw_of(input int b);
        return $clog2(b + 1);
    endfunction

    localparam int NOC_PV  = NOC_P * NOC_V;
    localparam int NOC_PFW = NOC_P * NOC_FW;
    localparam int NOC_CW  = cw_of(NOC_B);

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_DEC,
        CNT_INC
    } cnt_op_e;

endpackage

// File: rtl/out_port_credit_reg_credit_counter.sv
// Per-(port, VC) downstream credit counter with saturation and error detection.
module credit_counter
    import out_port_credit_reg_pkg::*;
#(
    parameter int B  = NOC_B,
    parameter int Cw = cw_of(B)
) (
    input  logic clk,
    input  logic reset,
    input  logic send,
    input  logic credit,
    output logic has_credit,
    output logic empty,
    output logic err
);

    localparam logic [Cw-1:0] FULL = Cw'(B);

    logic [Cw-1:0] cnt_q;
    logic [Cw-1:0] cnt_d;
    cnt_op_e       op;

    always_comb begin
        op = CNT_HOLD;
        if (send && !credit) begin
            op = CNT_DEC;
        end else if (credit && !send) begin
            op = CNT_INC;
        end
    end

    // Out-of-range requests saturate and raise a one-cycle error event.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        case (op)
            CNT_DEC: begin
                if (cnt_q == '0) err = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            CNT_INC: begin
                if (cnt_q == FULL) err = 1'b1;
                else               cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= FULL;
        else        cnt_q <= cnt_d;
    end

    assign has_credit = (cnt_q != '0);
    assign empty      = (cnt_q == FULL);

endmodule

// File: rtl/out_port_credit_reg.sv
// Output-port link register: one-cycle flit pipeline plus per-VC downstream credit tracking.
module out_port_credit_reg
    import out_port_credit_reg_pkg::*;
#(
    parameter int V  = NOC_V,
    parameter int P  = NOC_P,
    parameter int Fw = NOC_FW,
    parameter int B  = NOC_B
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [P*Fw-1:0] flit_in_all,
    input  logic [P-1:0]    flit_in_wr_all,
    input  logic [P*V-1:0]  flit_vc_all,
    input  logic [P*V-1:0]  credit_in_all,
    output logic [P*Fw-1:0] flit_out_all,
    output logic [P-1:0]    flit_out_wr_all,
    output logic [P*V-1:0]  vc_has_credit_all,
    output logic [P*V-1:0]  vc_empty_all,
    output logic [P-1:0]    credit_err_all
);

    localparam int Cw = cw_of(B);

    for (genvar p = 0; p < P; p++) begin : g_port
        logic [Fw-1:0] flit_q;
        logic          wr_q;
        logic          err_q;
        logic [V-1:0]  vc;
        logic [V-1:0]  cnt_err;
        logic          vc_ok;
        logic          vc_bad;

        assign vc     = flit_vc_all[p*V +: V];
        assign vc_ok  = $onehot(vc);
        // A malformed VC select still forwards the flit but charges no counter.
        assign vc_bad = flit_in_wr_all[p] && !vc_ok;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                flit_q <= '0;
                wr_q   <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                wr_q  <= flit_in_wr_all[p];
                err_q <= err_q | vc_bad | (|cnt_err);
                if (flit_in_wr_all[p]) flit_q <= flit_in_all[p*Fw +: Fw];
            end
        end

        for (genvar v = 0; v < V; v++) begin : g_vc
            credit_counter #(
                .B  (B),
                .Cw (Cw)
            ) u_cnt (
                .clk        (clk),
                .reset      (reset),
                .send       (flit_in_wr_all[p] && vc_ok && vc[v]),
                .credit     (credit_in_all[p*V+v]),
                .has_credit (vc_has_credit_all[p*V+v]),
                .empty      (vc_empty_all[p*V+v]),
                .err        (cnt_err[v])
            );
        end

        assign flit_out_all[p*Fw +: Fw] = flit_q;
        assign flit_out_wr_all[p]       = wr_q;
        assign credit_err_all[p]        = err_q;
    end

endmodule

// File: tb/tb_out_port_credit_reg.sv
// Scoreboard bench for out_port_credit_reg with P=5, V=2, Fw=36, B=4.
module tb_out_port_credit_reg;

    localparam int P  = 5;
    localparam int V  = 2;
    localparam int FW = 36;
    localparam int B  = 4;
    localparam int PV = P * V;
    localparam int W  = P * FW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  flit_in_all    = '0;
    logic [P-1:0]  flit_in_wr_all = '0;
    logic [PV-1:0] flit_vc_all    = '0;
    logic [PV-1:0] credit_in_all  = '0;
    logic [W-1:0]  flit_out_all;
    logic [P-1:0]  flit_out_wr_all;
    logic [PV-1:0] vc_has_credit_all;
    logic [PV-1:0] vc_empty_all;
    logic [P-1:0]  credit_err_all;

    always #5 clk = ~clk;

    out_port_credit_reg #(
        .V  (V),
        .P  (P),
        .Fw (FW),
        .B  (B)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .flit_in_all       (flit_in_all),
        .flit_in_wr_all    (flit_in_wr_all),
        .flit_vc_all       (flit_vc_all),
        .credit_in_all     (credit_in_all),
        .flit_out_all      (flit_out_all),
        .flit_out_wr_all   (flit_out_wr_all),
        .vc_has_credit_all (vc_has_credit_all),
        .vc_empty_all      (vc_empty_all),
        .credit_err_all    (credit_err_all)
    );

    typedef struct {
        int            cyc;
        logic [W-1:0]  flit;
        logic [P-1:0]  wr;
        logic [PV-1:0] has;
        logic [PV-1:0] emp;
        logic [P-1:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int           m_cnt[P][V];
    logic [W-1:0] m_flit;
    logic [P-1:0] m_wr;
    logic [P-1:0] m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        m_flit = '0;
        m_wr   = '0;
        m_err  = '0;
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++) m_cnt[p][v] = B;
    endtask

    task automatic model_edge();
        logic [V-1:0] vc;
        logic         ok, s, c;
        if (!rst_n) begin
            reset_model();
        end else begin
            for (int p = 0; p < P; p++) begin
                vc = flit_vc_all[p*V +: V];
                ok = $onehot(vc);
                m_wr[p] = flit_in_wr_all[p];
                if (flit_in_wr_all[p]) begin
                    m_flit[p*FW +: FW] = flit_in_all[p*FW +: FW];
                    if (!ok) m_err[p] = 1'b1;
                end
                for (int v = 0; v < V; v++) begin
                    s = flit_in_wr_all[p] && ok && vc[v];
                    c = credit_in_all[p*V+v];
                    if (s && !c) begin
                        if (m_cnt[p][v] == 0) m_err[p] = 1'b1;
                        else                  m_cnt[p][v]--;
                    end else if (c && !s) begin
                        if (m_cnt[p][v] == B) m_err[p] = 1'b1;
                        else                  m_cnt[p][v]++;
                    end
                end
            end
        end
    endtask

    // Apply current inputs across one rising edge, queueing the expected outputs.
    task automatic step();
        exp_t e;
        model_edge();
        e.cyc  = cyc + 1;
        e.flit = m_flit;
        e.wr   = m_wr;
        e.err  = m_err;
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++) begin
                e.has[p*V+v] = (m_cnt[p][v] != 0);
                e.emp[p*V+v] = (m_cnt[p][v] == B);
            end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flit_in_wr_all = '0;
        flit_vc_all    = '0;
        credit_in_all  = '0;
    endtask

    task automatic send(input int p, input int v, input logic [FW-1:0] d);
        flit_in_wr_all[p]       = 1'b1;
        flit_vc_all[p*V +: V]   = V'(1) << v;
        flit_in_all[p*FW +: FW] = d;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_flit"}, flit_out_all, '0);
        chk({tag, "_wr"}, W'(flit_out_wr_all), '0);
        chk({tag, "_has"}, W'(vc_has_credit_all), W'({PV{1'b1}}));
        chk({tag, "_empty"}, W'(vc_empty_all), W'({PV{1'b1}}));
        chk({tag, "_err"}, W'(credit_err_all), '0);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            me = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL stale_entry: expected cycle %0d, now %0d", me.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            me = sb.pop_front();
            chk("mon_flit", flit_out_all, me.flit);
            chk("mon_wr", W'(flit_out_wr_all), W'(me.wr));
            chk("mon_has", W'(vc_has_credit_all), W'(me.has));
            chk("mon_empty", W'(vc_empty_all), W'(me.emp));
            chk("mon_err", W'(credit_err_all), W'(me.err));
        end else if (flit_out_wr_all !== '0) begin
            chk("unexpected_wr", W'(flit_out_wr_all), '0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_vals("por");
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        step();
        step();

        // Single write on port 1 VC 0.
        send(1, 0, 36'hA5);
        step();
        chk("p1_flit", W'(flit_out_all[1*FW +: FW]), W'(36'hA5));
        chk("p1_wr", W'(flit_out_wr_all[1]), W'(1'b1));
        chk("p1v0_not_empty", W'(vc_empty_all[2]), W'(1'b0));
        clr();
        step();
        chk("p1_wr_drop", W'(flit_out_wr_all[1]), W'(1'b0));
        chk("p1_flit_hold", W'(flit_out_all[1*FW +: FW]), W'(36'hA5));

        // Drain port 2 VC 1, then underflow it.
        for (int i = 0; i < 4; i++) begin
            clr();
            send(2, 1, FW'(36'h200 + i));
            step();
        end
        chk("p2v1_no_credit", W'(vc_has_credit_all[5]), W'(1'b0));
        chk("p2_err_clear", W'(credit_err_all[2]), W'(1'b0));
        clr();
        send(2, 1, 36'h2FF);
        step();
        chk("p2_underflow_err", W'(credit_err_all[2]), W'(1'b1));
        chk("p2v1_stays_zero", W'(vc_has_credit_all[5]), W'(1'b0));
        chk("p2_underflow_fwd", W'(flit_out_all[2*FW +: FW]), W'(36'h2FF));
        clr();
        credit_in_all[5] = 1'b1;
        step();
        chk("p2v1_credit_back", W'(vc_has_credit_all[5]), W'(1'b1));

        // Port 0 VC 0 to count 2, then simultaneous send and credit.
        for (int i = 0; i < 2; i++) begin
            clr();
            send(0, 0, FW'(36'h100 + i));
            step();
        end
        clr();
        send(0, 0, 36'h1AB);
        credit_in_all[0] = 1'b1;
        step();
        chk("p0v0_has_same", W'(vc_has_credit_all[0]), W'(1'b1));
        chk("p0v0_empty_same", W'(vc_empty_all[0]), W'(1'b0));
        for (int i = 0; i < 2; i++) begin
            clr();
            credit_in_all[0] = 1'b1;
            step();
        end
        chk("p0v0_drained", W'(vc_empty_all[0]), W'(1'b1));
        chk("p0_err_clear", W'(credit_err_all[0]), W'(1'b0));

        // Overflow on port 4 VC 0 at reset level.
        clr();
        credit_in_all[8] = 1'b1;
        step();
        chk("p4_overflow_err", W'(credit_err_all[4]), W'(1'b1));
        chk("p4v0_still_full", W'(vc_empty_all[8]), W'(1'b1));
        clr();
        repeat (3) step();
        chk("p4_err_sticky", W'(credit_err_all[4]), W'(1'b1));

        // Non-one-hot VC select on port 3.
        clr();
        flit_in_wr_all[3]       = 1'b1;
        flit_vc_all[3*V +: V]   = 2'b11;
        flit_in_all[3*FW +: FW] = 36'h3C3C;
        step();
        chk("p3_fwd", W'(flit_out_all[3*FW +: FW]), W'(36'h3C3C));
        chk("p3_err", W'(credit_err_all[3]), W'(1'b1));
        chk("p3_counters", W'(vc_empty_all[7:6]), W'(2'b11));

        // All ports active in one cycle.
        clr();
        send(0, 0, 36'hA00);
        send(1, 1, 36'hA01);
        send(2, 1, 36'hA02);
        send(3, 0, 36'hA03);
        flit_in_wr_all[4] = 1'b1;
        flit_in_all[4*FW +: FW] = 36'hA04;
        credit_in_all[5] = 1'b1;
        credit_in_all[1] = 1'b1;
        step();
        clr();
        step();

        // Reset mid-burst with counter(1,0) at 1.
        for (int i = 0; i < 2; i++) begin
            clr();
            send(1, 0, FW'(36'hB00 + i));
            step();
        end
        clr();
        send(1, 0, 36'hB0F);
        credit_in_all[3] = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        reset_model();
        @(posedge clk);
        #1;
        step();
        step();
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        clr();
        send(1, 0, 36'hC0);
        step();
        chk("post_rst_flit", W'(flit_out_all[1*FW +: FW]), W'(36'hC0));
        chk("post_rst_empty", W'(vc_empty_all[2]), W'(1'b0));
        clr();
        step();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
